// File: rtl/chip8_loader_pkg.sv
// Shared definitions for the CHIP-8 SRAM load/dump path.
// Used by the ROM loader (host -> SRAM) and by ram_dumper (SRAM -> host).
// Contents:
//   SRAM_AW         - SRAM address width (4 KB space)
//   CHIP8_PROG_BASE - address where CHIP-8 programs start
//   state_t/ST_*    - FSM state codes shared by the loader and dumper
package chip8_loader_pkg;

  localparam int SRAM_AW = 12;

  localparam logic [SRAM_AW-1:0] CHIP8_PROG_BASE = 12'h200;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_READ    = 3'd1;
  localparam state_t ST_WAIT    = 3'd2;
  localparam state_t ST_CAPTURE = 3'd3;
  localparam state_t ST_SEND    = 3'd4;
  localparam state_t ST_RELEASE = 3'd5;
  localparam state_t ST_DONE    = 3'd6;

endpackage

// File: rtl/byte_packer.sv
// Assembles SRAM bytes into a big-endian 32-bit word.
// The first byte of a word lands in [31:24], the fourth in [7:0].
// Ports:
//   clk    - system clock
//   reset  - synchronous active-high reset (word and lane cleared)
//   clear  - synchronous clear for starting a new word
//   insert - write data into the current lane and advance the lane
//   data   - byte to insert
//   word   - assembled word (lanes never written stay 0x00)
//   lane   - index of the next lane to be written (0..3)
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        insert,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic [1:0]  lane
);

  // Lane n occupies bits [31-8n -: 8]; ~lane equals 3-lane, so the
  // bit offset of lane n is {~lane, 3'b000}.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= '0;
      lane <= '0;
    end else if (insert) begin
      word[{~lane, 3'b000} +: 8] <= data;
      lane                       <= lane + 2'd1;
    end
  end

endmodule

// File: rtl/ram_dumper.sv
// Streams a byte range of the CHIP-8 4 KB SRAM to the host control module
// as big-endian 32-bit words over a 4-phase req/ack handshake. The core is
// held in reset while a dump is in progress.
// Ports:
//   clk                 - system clock
//   reset               - synchronous active-high reset
//   start               - one-cycle pulse, begins a dump when idle
//   host_dumpdata_reset - synchronous abort from host, same effect as reset
//   host_dumpdata_size  - number of bytes to dump, sampled at start
//   sram_addr           - SRAM read address (wraps modulo 4096)
//   sram_rdata          - SRAM read data, valid RD_LAT cycles after address
//   sram_oe_n           - active-low SRAM read enable
//   host_dumpdata       - packed word presented to the host
//   host_dumpdata_req   - word valid / request to host
//   host_dumpdata_ack   - host acknowledge
//   dumping             - high from accepted start until the dump is done
//   rst_n               - core reset, low while in reset or dumping
module ram_dumper
  import chip8_loader_pkg::*;
#(
  parameter logic [SRAM_AW-1:0] BASE_ADDR = CHIP8_PROG_BASE,
  parameter int                 RD_LAT    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               host_dumpdata_reset,
  input  logic [15:0]        host_dumpdata_size,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [7:0]         sram_rdata,
  output logic               sram_oe_n,
  output logic [31:0]        host_dumpdata,
  output logic               host_dumpdata_req,
  input  logic               host_dumpdata_ack,
  output logic               dumping,
  output logic               rst_n
);

  localparam logic [1:0] LAT = RD_LAT[1:0];

  state_t      state;
  logic [15:0] remaining;
  logic [1:0]  wait_cnt;
  logic        dumping_r;
  logic        sync_reset;
  logic        accept;
  logic        last_byte;
  logic        pk_clear;
  logic        pk_insert;
  logic [1:0]  lane;

  assign sync_reset = reset | host_dumpdata_reset;
  assign accept     = (state == ST_IDLE) & start & ~sync_reset;

  // The accepted start cycle already counts as dumping so the core is
  // held in reset from the very cycle the host asks for the dump.
  assign dumping = dumping_r | accept;
  assign rst_n   = ~(sync_reset | dumping);

  // A word is complete after its fourth byte or after the last byte of
  // the range, whichever comes first.
  assign last_byte = (lane == 2'd3) || (remaining == 16'd1);

  // The word buffer is cleared when a dump starts and when the host has
  // released a word and more bytes follow.
  assign pk_clear  = accept |
                     ((state == ST_RELEASE) & ~host_dumpdata_ack & (remaining != 16'd0));
  assign pk_insert = (state == ST_CAPTURE);

  byte_packer u_packer (
    .clk    (clk),
    .reset  (sync_reset),
    .clear  (pk_clear),
    .insert (pk_insert),
    .data   (sram_rdata),
    .word   (host_dumpdata),
    .lane   (lane)
  );

  // Main dump FSM. req is raised on the way into SEND so that an ack
  // already high on entry completes the transfer on the first SEND edge.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state             <= ST_IDLE;
      sram_addr         <= BASE_ADDR;
      sram_oe_n         <= 1'b1;
      host_dumpdata_req <= 1'b0;
      dumping_r         <= 1'b0;
      remaining         <= '0;
      wait_cnt          <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            remaining <= host_dumpdata_size;
            sram_addr <= BASE_ADDR;
            dumping_r <= 1'b1;
            state     <= (host_dumpdata_size == 16'd0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          sram_oe_n <= 1'b0;
          wait_cnt  <= LAT;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt <= 2'd1) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          sram_addr <= sram_addr + 12'd1;
          remaining <= remaining - 16'd1;
          if (last_byte) begin
            sram_oe_n         <= 1'b1;
            host_dumpdata_req <= 1'b1;
            state             <= ST_SEND;
          end else begin
            state <= ST_READ;
          end
        end
        ST_SEND: begin
          if (host_dumpdata_ack) begin
            host_dumpdata_req <= 1'b0;
            state             <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!host_dumpdata_ack) begin
            state <= (remaining == 16'd0) ? ST_DONE : ST_READ;
          end
        end
        ST_DONE: begin
          dumping_r <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_dumper.md
Name: ram_dumper

Overview:
- Reverse-direction companion to the host ROM loading path: reads a byte range out of the CHIP-8 4 KB SRAM and streams it to the host control module as big-endian 32-bit words over a 4-phase req/ack handshake.
- Sits between the SRAM arbiter and the host control module.
- Used for RAM save/inspect from the OSD; holds the core in reset while dumping.

Parameters:
- BASE_ADDR, 12'h200, first SRAM address read (CHIP-8 program start).
- RD_LAT, 1, SRAM read latency in clk cycles from sram_addr change to valid sram_rdata (legal 1..3).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a dump when IDLE, ignored otherwise.
- host_dumpdata_reset  in  1  synchronous abort/restart from host; same effect as reset.
- host_dumpdata_size  in  16  byte count to dump; sampled at start.
- sram_addr  out  12  SRAM read address.
- sram_rdata  in  8  SRAM read data.
- sram_oe_n  out  1  active-low read enable; low only while reading.
- host_dumpdata  out  32  packed word; byte N at [31:24], N+3 at [7:0].
- host_dumpdata_req  out  1  word valid / request to host.
- host_dumpdata_ack  in  1  host acknowledge.
- dumping  out  1  high from accepted start until DONE.
- rst_n  out  1  core reset: 0 while reset or dumping, else 1.

Behaviour:
- Reset (reset or host_dumpdata_reset), applied next edge: state IDLE, sram_addr=BASE_ADDR, sram_oe_n=1, host_dumpdata=0, req=0, dumping=0, byte counter=0. rst_n combinational: 0 during reset.
- Abort mid-operation: req drops on the next edge even if ack is high; a partial word is discarded.
- State machine:
  - IDLE: on start, latch size into remaining (16 bit), set addr=BASE_ADDR, lane=0, dumping=1. Go to DONE if size==0, else READ.
  - READ: oe_n=0, wait counter=RD_LAT. Go to WAIT.
  - WAIT: decrement; at 0 go to CAPTURE.
  - CAPTURE: write sram_rdata into lane (lane0 -> [31:24]); addr+1 (12-bit wrap FFF->000); remaining-1; lane+1.
    - If lane was 3 or remaining becomes 0: oe_n=1, go to SEND.
    - Else go to READ.
  - SEND: req=1; word stable while req=1. When ack=1, req=0 and go to RELEASE.
  - RELEASE: wait ack=0.
    - If remaining==0, go to DONE.
    - Else clear word to 0, lane=0, go to READ.
  - DONE: dumping=0, go to IDLE.
- Final partial word: unused low lanes are 0x00.
- Ack handling: ack while req=0 is ignored. Ack already high on entry to SEND completes that cycle; RELEASE then waits for ack to fall.
- Per-byte cost: 2+RD_LAT cycles. Size up to 65535 is legal; addresses wrap modulo 4096.
- Start during a dump is ignored. Start and abort in the same cycle: abort wins.

Decomposition:
- Shared package chip8_loader_pkg:
  - state enum (IDLE, READ, WAIT, CAPTURE, SEND, RELEASE, DONE),
  - CHIP8_PROG_BASE=12'h200,
  - SRAM_AW=12.
- rom_loader uses the same base constant from this package.
- One natural sub-module: byte_packer (lane counter, 32-bit shift/insert, clear). The FSM stays in ram_dumper.

Test Plan:
- Setup: SRAM model preloaded 0x200..0x207 = 00 E0 A2 2A 60 0C 61 08; RD_LAT=1; host acks 2 cycles after req and drops ack 1 cycle after req falls.
- size=8, start pulse -> two words 32'h00E0A22A then 32'h600C6108; dumping high throughout, then low; rst_n=0 during the dump.
- size=6 -> words 32'h00E0A22A then 32'h600C0000; exactly 2 req pulses; final sram_addr=12'h206.
- size=0 -> no req; dumping high for exactly 2 cycles.
- Wrap: BASE_ADDR=12'hFFE, size=4, SRAM FFE=11, FFF=22, 000=33, 001=44 -> word 32'h11223344.
- Abort: host_dumpdata_reset asserted while req=1 -> req=0 next cycle, state IDLE, sram_addr=BASE_ADDR. A later start re-dumps from byte 0.
- Handshake robustness:
  - Host holds ack high 10 cycles -> no second word until ack falls.
  - Start pulse mid-dump -> ignored; total word count unchanged.
  - Repeat the size=8 case with RD_LAT=3 -> same data.
